// File: rtl/pmsm_pkg.sv
// Shared PMSM drive definitions: phase codes,
// FSM state encodings and sector thresholds.
package pmsm_pkg;

  localparam logic [2:0] VP_OFF   = 3'b000;
  localparam logic [2:0] VP_S0    = 3'b001;
  localparam logic [2:0] VP_S1    = 3'b011;
  localparam logic [2:0] VP_S2    = 3'b010;
  localparam logic [2:0] VP_S3    = 3'b110;
  localparam logic [2:0] VP_S4    = 3'b100;
  localparam logic [2:0] VP_S5    = 3'b101;
  localparam logic [2:0] VP_BRAKE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_RUN   = 3'd2,
    ST_DEAD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [15:0] SEC_TH1 = 16'd10923;
  localparam logic [15:0] SEC_TH2 = 16'd21845;
  localparam logic [15:0] SEC_TH3 = 16'd32768;
  localparam logic [15:0] SEC_TH4 = 16'd43691;
  localparam logic [15:0] SEC_TH5 = 16'd54613;

  function automatic logic [2:0] sector_code(
    input logic [2:0] s
  );
    logic [2:0] c;
    case (s)
      3'd0:    c = VP_S0;
      3'd1:    c = VP_S1;
      3'd2:    c = VP_S2;
      3'd3:    c = VP_S3;
      3'd4:    c = VP_S4;
      3'd5:    c = VP_S5;
      default: c = VP_OFF;
    endcase
    return c;
  endfunction

  // |x| with -32768 saturating to 32767
  function automatic logic [15:0] abs_sat(
    input logic signed [15:0] x
  );
    logic [15:0] a;
    if (x == 16'sh8000)
      a = 16'h7fff;
    else if (x[15])
      a = 16'(-x);
    else
      a = 16'(x);
    return a;
  endfunction

endpackage

// File: rtl/sector_decode.sv
// Maps electrical angle (plus phase advance)
// to a six-step drive sector, honouring direction.
module sector_decode
  import pmsm_pkg::*;
#(
  parameter logic [15:0] ADVANCE = 16'd0
) (
  input  logic [15:0] position,
  input  logic        dir,
  output logic [2:0]  sector
);

  logic [15:0] p;
  logic [2:0]  s;

  // threshold decode of the advanced angle
  always_comb begin
    p = position + ADVANCE;
    s = 3'd0;
    unique case (1'b1)
      (p < SEC_TH1):                 s = 3'd0;
      (p >= SEC_TH1 && p < SEC_TH2): s = 3'd1;
      (p >= SEC_TH2 && p < SEC_TH3): s = 3'd2;
      (p >= SEC_TH3 && p < SEC_TH4): s = 3'd3;
      (p >= SEC_TH4 && p < SEC_TH5): s = 3'd4;
      (p >= SEC_TH5):                s = 3'd5;
    endcase
    if (dir)
      sector = (s >= 3'd3) ? s - 3'd3 : s + 3'd3;
    else
      sector = s;
  end

endmodule

// File: rtl/six_step_commutator.sv
// Six-step commutation drive stage: align, run,
// dead-time, PWM gating and latched overcurrent.
module six_step_commutator
  import pmsm_pkg::*;
#(
  parameter int          PWM_PERIOD   = 64,
  parameter int          DEAD_CYCLES  = 4,
  parameter int          ALIGN_CYCLES = 256,
  parameter logic [15:0] ADVANCE      = 16'd0,
  parameter logic [15:0] I_LIMIT      = 16'd20000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               dir,
  input  logic [7:0]         duty,
  input  logic [15:0]        position,
  input  logic signed [15:0] I_a,
  input  logic signed [15:0] I_b,
  input  logic signed [15:0] I_c,
  output logic [2:0]         V_phase,
  output logic [2:0]         sector,
  output logic [2:0]         state,
  output logic               fault
);

  localparam int CW = $clog2(PWM_PERIOD);
  localparam int AW = $clog2(ALIGN_CYCLES + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);

  localparam logic [CW-1:0] PWM_LAST =
    CW'(PWM_PERIOD - 1);
  localparam logic [AW-1:0] ALIGN_LAST =
    AW'(ALIGN_CYCLES - 1);
  localparam logic [DW-1:0] DEAD_LOAD =
    DW'(DEAD_CYCLES - 1);

  state_t        st_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic [AW-1:0] acnt_q;
  logic [DW-1:0] dcnt_q;
  logic [2:0]    sec_q;
  logic [2:0]    dsec;
  logic [31:0]   on_time;
  logic          pwm_on;
  logic          oc;

  sector_decode #(
    .ADVANCE (ADVANCE)
  ) u_dec (
    .position (position),
    .dir      (dir),
    .sector   (dsec)
  );

  // duty window, PWM wrap and overcurrent detect
  always_comb begin
    on_time = (32'(duty) * 32'(PWM_PERIOD)) >> 8;
    pwm_on  = 32'(cnt_q) < on_time;
    cnt_nxt = (cnt_q == PWM_LAST) ? '0
                                  : cnt_q + CW'(1);
    oc = (abs_sat(I_a) > I_LIMIT) ||
         (abs_sat(I_b) > I_LIMIT) ||
         (abs_sat(I_c) > I_LIMIT);
  end

  // commutation FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      V_phase <= VP_OFF;
      sec_q   <= 3'd0;
      fault   <= 1'b0;
      cnt_q   <= '0;
      acnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          V_phase <= VP_OFF;
          if (enable && !fault) begin
            st_q    <= ST_ALIGN;
            acnt_q  <= '0;
            V_phase <= VP_S0;
          end
        end
        ST_ALIGN: begin
          if (oc) begin
            st_q    <= ST_FAULT;
            fault   <= 1'b1;
            V_phase <= VP_OFF;
          end else if (!enable) begin
            st_q    <= ST_IDLE;
            V_phase <= VP_OFF;
          end else if (acnt_q == ALIGN_LAST) begin
            // this edge is PWM slot 0 of the run
            st_q    <= ST_RUN;
            sec_q   <= dsec;
            cnt_q   <= CW'(1);
            V_phase <= (on_time != 32'd0)
                       ? sector_code(dsec) : VP_OFF;
          end else begin
            acnt_q  <= acnt_q + AW'(1);
            V_phase <= VP_S0;
          end
        end
        ST_RUN: begin
          if (oc) begin
            st_q    <= ST_FAULT;
            fault   <= 1'b1;
            V_phase <= VP_OFF;
          end else if (!enable) begin
            st_q    <= ST_IDLE;
            V_phase <= VP_OFF;
          end else begin
            cnt_q <= cnt_nxt;
            if (dsec != sec_q) begin
              st_q    <= ST_DEAD;
              sec_q   <= dsec;
              dcnt_q  <= DEAD_LOAD;
              V_phase <= VP_OFF;
            end else begin
              V_phase <= pwm_on ? sector_code(sec_q)
                                : VP_OFF;
            end
          end
        end
        ST_DEAD: begin
          if (oc) begin
            st_q    <= ST_FAULT;
            fault   <= 1'b1;
            V_phase <= VP_OFF;
          end else if (!enable) begin
            st_q    <= ST_IDLE;
            V_phase <= VP_OFF;
          end else begin
            cnt_q <= cnt_nxt;
            sec_q <= dsec;
            if (dcnt_q == '0) begin
              st_q    <= ST_RUN;
              V_phase <= pwm_on ? sector_code(dsec)
                                : VP_OFF;
            end else begin
              dcnt_q  <= dcnt_q - DW'(1);
              V_phase <= VP_OFF;
            end
          end
        end
        ST_FAULT: begin
          V_phase <= VP_OFF;
          if (!enable) begin
            st_q  <= ST_IDLE;
            fault <= 1'b0;
          end
        end
        default: begin
          st_q    <= ST_IDLE;
          V_phase <= VP_OFF;
        end
      endcase
    end
  end

  assign sector = sec_q;
  assign state  = st_q;

endmodule

// File: tb/tb_six_step_commutator.sv
// Scoreboard bench for six_step_commutator against
// a behavioural model of the commutation rules.
module tb_six_step_commutator;
  import pmsm_pkg::*;

  localparam int P     = 64;
  localparam int DEADN = 4;
  localparam int ALIGN = 256;
  localparam int LIM   = 20000;
  localparam int ADV2  = 60000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               dir = 1'b0;
  logic [7:0]         duty = 8'd0;
  logic [15:0]        position = 16'd0;
  logic signed [15:0] I_a = 16'sd0;
  logic signed [15:0] I_b = 16'sd0;
  logic signed [15:0] I_c = 16'sd0;

  logic [2:0] v0, s0, st0, v1, s1, st1;
  logic       f0, f1;

  int checks = 0;
  int errors = 0;
  bit cur_rand = 1'b1;

  always #5 clk = ~clk;

  six_step_commutator dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .dir(dir), .duty(duty), .position(position),
    .I_a(I_a), .I_b(I_b), .I_c(I_c),
    .V_phase(v0), .sector(s0), .state(st0),
    .fault(f0)
  );

  six_step_commutator #(
    .ADVANCE(16'd60000)
  ) dut_adv (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .dir(dir), .duty(duty), .position(position),
    .I_a(I_a), .I_b(I_b), .I_c(I_c),
    .V_phase(v1), .sector(s1), .state(st1),
    .fault(f1)
  );

  typedef struct {
    int mode;
    int align_n;
    int dead_n;
    int tick;
    int sec;
    bit flt;
    int v;
  } model_t;

  typedef struct packed {
    logic [2:0] v;
    logic [2:0] sec;
    logic [2:0] st;
    logic       flt;
  } obs_t;

  obs_t q0[$];
  obs_t q1[$];

  int codes[6] = '{1, 3, 2, 6, 4, 5};
  int th[5] = '{10923, 21845, 32768, 43691, 54613};

  function automatic int drive_sector(
    int pos, bit d, int adv
  );
    int p;
    int s;
    p = (pos + adv) % 65536;
    s = 0;
    foreach (th[i]) if (p >= th[i]) s++;
    return d ? (s + 3) % 6 : s;
  endfunction

  function automatic int mag(int x);
    int a;
    a = (x < 0) ? -x : x;
    return (a > 32767) ? 32767 : a;
  endfunction

  function automatic model_t m_reset();
    model_t m;
    m.mode = 0; m.align_n = 0; m.dead_n = 0;
    m.tick = 0; m.sec = 0; m.flt = 0; m.v = 0;
    return m;
  endfunction

  function automatic int pwm_val(
    int tick, int on, int sec
  );
    return ((tick % P) < on) ? codes[sec] : 0;
  endfunction

  function automatic model_t mstep(
    model_t m, bit en, bit d, int dt,
    int pos, bit oc, int adv
  );
    int on;
    int ds;
    on = dt * P / 256;
    ds = drive_sector(pos, d, adv);
    if (m.mode != 0 && m.mode != 4 && oc) begin
      m.mode = 4; m.flt = 1; m.v = 0;
    end else if (m.mode != 0 && m.mode != 4
                 && !en) begin
      m.mode = 0; m.v = 0;
    end else begin
      case (m.mode)
        0: begin
          m.v = 0;
          if (en && !m.flt) begin
            m.mode = 1; m.align_n = 1; m.v = 1;
          end
        end
        1: begin
          if (m.align_n == ALIGN) begin
            m.mode = 2; m.sec = ds; m.tick = 0;
            m.v = pwm_val(m.tick, on, m.sec);
            m.tick++;
          end else begin
            m.align_n++; m.v = 1;
          end
        end
        2: begin
          if (ds != m.sec) begin
            m.mode = 3; m.sec = ds;
            m.dead_n = 1; m.v = 0;
          end else begin
            m.v = pwm_val(m.tick, on, m.sec);
          end
          m.tick++;
        end
        3: begin
          m.sec = ds;
          if (m.dead_n == DEADN) begin
            m.mode = 2;
            m.v = pwm_val(m.tick, on, m.sec);
          end else begin
            m.dead_n++; m.v = 0;
          end
          m.tick++;
        end
        default: begin
          m.v = 0;
          if (!en) begin m.mode = 0; m.flt = 0; end
        end
      endcase
    end
    return m;
  endfunction

  function automatic obs_t to_obs(model_t m);
    obs_t o;
    o.v = 3'(m.v); o.sec = 3'(m.sec);
    o.st = 3'(m.mode); o.flt = m.flt;
    return o;
  endfunction

  // model: one step per rising edge, push expected
  initial begin : model_proc
    model_t m0, m1;
    bit oc;
    m0 = m_reset(); m1 = m_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m0 = m_reset(); m1 = m_reset();
      end else begin
        oc = (mag(int'(I_a)) > LIM) ||
             (mag(int'(I_b)) > LIM) ||
             (mag(int'(I_c)) > LIM);
        m0 = mstep(m0, enable, dir, int'(duty),
                   int'(position), oc, 0);
        m1 = mstep(m1, enable, dir, int'(duty),
                   int'(position), oc, ADV2);
      end
      q0.push_back(to_obs(m0));
      q1.push_back(to_obs(m1));
    end
  end

  task automatic cmp_obs(
    string name, ref obs_t q[$], input obs_t got
  );
    obs_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s t=%0t no expected entry",
               name, $time);
    end else begin
      e = q.pop_front();
      if (got !== e) begin
        errors++;
        $display({"FAIL %s t=%0t got v=%b sec=%0d ",
                  "st=%0d f=%b expected v=%b sec=%0d ",
                  "st=%0d f=%b"}, name, $time,
                 got.v, got.sec, got.st, got.flt,
                 e.v, e.sec, e.st, e.flt);
      end
    end
  endtask

  // monitor: pop and compare just after each edge
  initial begin : monitor_proc
    forever begin
      @(posedge clk);
      #1;
      cmp_obs("main", q0, {v0, s0, st0, f0});
      cmp_obs("adv", q1, {v1, s1, st1, f1});
    end
  end

  task automatic check(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               name, got, exp);
    end
  endtask

  function automatic logic signed [15:0] safe_i();
    return 16'(int'($urandom_range(0, 2 * LIM)) - LIM);
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      if (cur_rand) begin
        I_a = safe_i(); I_b = safe_i(); I_c = safe_i();
      end
    end
  endtask

  task automatic count_code(
    int n, logic [2:0] code, output int c
  );
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (v0 == code) c++;
    end
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    check("rst_v", int'(v0), 0);
    check("rst_state", int'(st0), 0);
    check("rst_fault", int'(f0), 0);
    check("rst_sector", int'(s0), 0);
  endtask

  initial begin : stim
    int c;
    tick(4);
    rst_n = 1'b1;
    tick(10);
    check("idle_off", int'(v0), 0);

    duty = 8'd255; enable = 1'b1; position = 16'd0;
    tick(10);
    check("align_code", int'(v0), 1);
    tick(ALIGN + 60);
    check("run_state", int'(st0), 2);
    count_code(64, VP_S0, c);
    check("duty255_s0", c, 63);

    for (int k = 0; k < 6; k++) begin
      position = 16'(k * 12000);
      tick(150);
      check("sweep_sector", int'(s0), k);
    end

    position = 16'd0;
    tick(80);
    duty = 8'd128;
    tick(70);
    count_code(64, VP_S0, c);
    check("duty128", c, 32);
    duty = 8'd0;
    tick(5);
    count_code(64, VP_OFF, c);
    check("duty0", c, 64);

    duty = 8'd255; dir = 1'b1; position = 16'd5000;
    tick(20);
    check("rev_sector", int'(s0), 3);
    count_code(64, VP_S3, c);
    check("rev_code", c, 63);

    dir = 1'b0; position = 16'd10000;
    tick(20);
    check("adv_wrap", int'(s1), 0);
    position = 16'd60000;
    tick(20);
    check("adv_sector", int'(s1), 4);
    check("noadv_sector", int'(s0), 5);

    repeat (20) begin
      duty = 8'($urandom);
      position = 16'($urandom);
      dir = 1'($urandom);
      tick($urandom_range(5, 60));
    end

    cur_rand = 1'b0;
    I_a = 16'sd20000; I_b = -16'sd20000;
    I_c = 16'sd20000;
    tick(10);
    check("no_trip_edge", int'(f0), 0);
    I_a = 16'sd0; I_c = 16'sd0; I_b = -16'sd20001;
    tick(1);
    check("oc_fault", int'(f0), 1);
    check("oc_off", int'(v0), 0);
    I_b = 16'sd0;
    tick(20);
    check("fault_hold", int'(st0), 4);
    enable = 1'b0;
    tick(1);
    check("fault_clear", int'(f0), 0);
    tick(5);
    enable = 1'b1; cur_rand = 1'b1;
    tick(50);
    cur_rand = 1'b0;
    I_c = -16'sh8000;
    tick(1);
    check("oc_align", int'(f0), 1);
    enable = 1'b0;
    tick(2);
    I_c = 16'sd0; enable = 1'b1; cur_rand = 1'b1;
    tick(ALIGN + 50);

    reset_now();
    tick(3);
    rst_n = 1'b1; enable = 1'b0;
    tick(10);
    check("post_rst_off", int'(v0), 0);

    repeat (150) begin
      enable = ($urandom_range(0, 9) != 0);
      duty = 8'($urandom);
      position = 16'($urandom);
      dir = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 14) == 0) begin
        cur_rand = 1'b0; I_a = 16'sd20001;
      end else begin
        cur_rand = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) begin
        reset_now();
        tick(2);
        rst_n = 1'b1;
      end
      tick($urandom_range(1, 40));
    end

    cur_rand = 1'b1;
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
